// File: rtl/sprite_plotter.sv
// Erases a WxH sprite at its previous position, then redraws it at the position captured at start.
// Optional clipping to SCREEN_W x SCREEN_H is enabled by the macro SPRITE_PLOTTER_CLIP_EN.
module sprite_plotter #(
   parameter int         SPRITE_W  = 4,
   parameter int         SPRITE_H  = 4,
   parameter logic [2:0] BG_COLOUR = 3'b000,
   parameter int         SCREEN_W  = 160,
   parameter int         SCREEN_H  = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] new_x,
   input  logic [6:0] new_y,
   input  logic [2:0] sprite_colour,
   output logic       busy,
   output logic       done,
   output logic       plot,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour
);

   if (SPRITE_W < 1 || SPRITE_W > 16 || SPRITE_H < 1 || SPRITE_H > 16 ||
       SCREEN_W < 1 || SCREEN_W > 256 || SCREEN_H < 1 || SCREEN_H > 128) begin : g_param_check
      $error("sprite_plotter: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;

   localparam logic [3:0] LAST_DX = 4'(SPRITE_W - 1);
   localparam logic [3:0] LAST_DY = 4'(SPRITE_H - 1);

   state_t     state, state_nx;
   logic [3:0] dx, dy, dx_nx, dy_nx;
   logic [7:0] cap_x, cap_x_nx, old_x, old_x_nx;
   logic [6:0] cap_y, cap_y_nx, old_y, old_y_nx;
   logic [2:0] cap_col, cap_col_nx;
   logic       have_old, have_old_nx;
   logic       busy_nx, done_nx, plot_nx;
   logic [7:0] x_nx;
   logic [6:0] y_nx;
   logic [2:0] colour_nx;

   logic [7:0] base_x, pix_x;
   logic [6:0] base_y, pix_y;
   logic       visible;

   assign base_x = (state == ERASE) ? old_x : cap_x;
   assign base_y = (state == ERASE) ? old_y : cap_y;

`ifdef SPRITE_PLOTTER_CLIP_EN
   // One bit wider than the port so off-screen pixels are not hidden by wrap-around.
   logic [8:0] ux;
   logic [7:0] uy;
   assign ux      = {1'b0, base_x} + {5'b0, dx};
   assign uy      = {1'b0, base_y} + {4'b0, dy};
   assign pix_x   = ux[7:0];
   assign pix_y   = uy[6:0];
   assign visible = (32'(ux) < SCREEN_W) && (32'(uy) < SCREEN_H);
`else
   assign pix_x   = base_x + {4'b0, dx};
   assign pix_y   = base_y + {3'b0, dy};
   assign visible = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         dx       <= '0;
         dy       <= '0;
         cap_x    <= '0;
         cap_y    <= '0;
         cap_col  <= '0;
         old_x    <= '0;
         old_y    <= '0;
         have_old <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         plot     <= 1'b0;
         x        <= '0;
         y        <= '0;
         colour   <= '0;
      end else begin
         state    <= state_nx;
         dx       <= dx_nx;
         dy       <= dy_nx;
         cap_x    <= cap_x_nx;
         cap_y    <= cap_y_nx;
         cap_col  <= cap_col_nx;
         old_x    <= old_x_nx;
         old_y    <= old_y_nx;
         have_old <= have_old_nx;
         busy     <= busy_nx;
         done     <= done_nx;
         plot     <= plot_nx;
         x        <= x_nx;
         y        <= y_nx;
         colour   <= colour_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      dx_nx       = dx;
      dy_nx       = dy;
      cap_x_nx    = cap_x;
      cap_y_nx    = cap_y;
      cap_col_nx  = cap_col;
      old_x_nx    = old_x;
      old_y_nx    = old_y;
      have_old_nx = have_old;
      busy_nx     = busy;
      done_nx     = 1'b0;
      plot_nx     = 1'b0;
      x_nx        = x;
      y_nx        = y;
      colour_nx   = colour;

      case (state)
         IDLE: begin
            if (start) begin
               cap_x_nx   = new_x;
               cap_y_nx   = new_y;
               cap_col_nx = sprite_colour;
               dx_nx      = '0;
               dy_nx      = '0;
               busy_nx    = 1'b1;
               state_nx   = have_old ? ERASE : DRAW;
            end
         end
         ERASE, DRAW: begin
            plot_nx = visible;
            if (visible) begin
               x_nx      = pix_x;
               y_nx      = pix_y;
               colour_nx = (state == ERASE) ? BG_COLOUR : cap_col;
            end
            // Row-major scan; the last pixel of the erase rectangle hands over to the draw pass.
            if (dx == LAST_DX) begin
               dx_nx = '0;
               if (dy == LAST_DY) begin
                  dy_nx    = '0;
                  state_nx = (state == ERASE) ? DRAW : FINISH;
               end else begin
                  dy_nx = dy + 4'd1;
               end
            end else begin
               dx_nx = dx + 4'd1;
            end
         end
         FINISH: begin
            done_nx     = 1'b1;
            busy_nx     = 1'b0;
            old_x_nx    = cap_x;
            old_y_nx    = cap_y;
            have_old_nx = 1'b1;
            state_nx    = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter: a rectangle-level model queues expected pixels and done cycles.
module tb_sprite_plotter;
   localparam int W = 4;
   localparam int H = 4;
   localparam logic [2:0] BG = 3'b000;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] new_x;
   logic [6:0] new_y;
   logic [2:0] sprite_colour;
   logic       busy, done, plot;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [17:0] exp_pix[$];
   int          exp_done[$];
   bit          m_have_old = 1'b0;
   int          m_ox = 0, m_oy = 0;

   sprite_plotter dut (
      .clk(clk), .reset(reset), .start(start), .new_x(new_x), .new_y(new_y),
      .sprite_colour(sprite_colour), .busy(busy), .done(done), .plot(plot),
      .x(x), .y(y), .colour(colour)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Monitor: every plot and every done pulse is checked against the scoreboard.
   always @(negedge clk) begin
      if (plot) begin
         checks++;
         if (exp_pix.size() == 0) begin
            errors++;
            $display("FAIL plot_unexpected: got x=%0d y=%0d c=%0d, expected no plot", x, y, colour);
         end else begin
            logic [17:0] e;
            e = exp_pix.pop_front();
            if ({x, y, colour} !== e) begin
               errors++;
               $display("FAIL plot_pixel: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                        x, y, colour, e[17:10], e[9:3], e[2:0]);
            end
         end
      end
      if (done) begin
         checks++;
         if (exp_done.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: done at cycle %0d, expected none", cyc);
         end else begin
            int d;
            d = exp_done.pop_front();
            if (cyc != d) begin
               errors++;
               $display("FAIL done_cycle: got cycle %0d, expected cycle %0d", cyc, d);
            end
         end
         checks++;
         if (exp_pix.size() != 0) begin
            errors++;
            $display("FAIL done_pixels_left: got %0d pixels still pending, expected 0", exp_pix.size());
         end
      end
   end

   task automatic push_rect(input int bx, input int by, input logic [2:0] c);
      for (int j = 0; j < H; j++) begin
         for (int i = 0; i < W; i++) begin
            int ux, uy;
            logic [7:0] xx;
            logic [6:0] yy;
            ux = bx + i;
            uy = by + j;
`ifdef SPRITE_PLOTTER_CLIP_EN
            if (ux >= 160 || uy >= 120) continue;
`endif
            xx = 8'(ux % 256);
            yy = 7'(uy % 128);
            exp_pix.push_back({xx, yy, c});
         end
      end
   endtask

   task automatic model_pass(input int px, input int py, input logic [2:0] pc, input int acc);
      int n;
      n = m_have_old ? 2 : 1;
      if (m_have_old) push_rect(m_ox, m_oy, BG);
      push_rect(px, py, pc);
      exp_done.push_back(acc + n * W * H + 1);
      m_have_old = 1'b1;
      m_ox = px;
      m_oy = py;
   endtask

   task automatic issue_start(input int px, input int py, input logic [2:0] pc);
      @(negedge clk);
      start         = 1'b1;
      new_x         = 8'(px);
      new_y         = 7'(py);
      sprite_colour = pc;
      model_pass(px, py, pc, cyc + 1);
      @(negedge clk);
      start         = 1'b0;
      new_x         = 8'($urandom);
      new_y         = 7'($urandom);
      sprite_colour = 3'($urandom);
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done within 200 cycles, expected a done pulse");
      end
   endtask

   task automatic run_pass(input int px, input int py, input logic [2:0] pc, input bit pulse);
      issue_start(px, py, pc);
      if (pulse) begin
         repeat (3) @(negedge clk);
         start = 1'b1;
         new_x = 8'($urandom);
         @(negedge clk);
         start = 1'b0;
      end
      wait_done();
      repeat (2) @(negedge clk);
   endtask

   task automatic check_bit(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0b, expected %0b", name, got, want);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; new_x = '0; new_y = '0; sprite_colour = '0;
      repeat (3) @(negedge clk);
      check_bit("reset_busy", busy, 1'b0);
      check_bit("reset_done", done, 1'b0);
      check_bit("reset_plot", plot, 1'b0);
      checks++;
      if ({x, y, colour} !== 18'd0) begin
         errors++;
         $display("FAIL reset_xyc: got x=%0d y=%0d c=%0d, expected 0 0 0", x, y, colour);
      end
      reset = 1'b0;
      @(negedge clk);

      run_pass(10, 20, 3'b100, 1'b0);
      run_pass(12, 20, 3'b010, 1'b0);
      run_pass(30, 40, 3'b111, 1'b1);

      // Reset during the 8th draw pixel of an erase+draw pass.
      issue_start(50, 60, 3'b011);
      repeat (W * H + 7) @(negedge clk);
      check_bit("pre_reset_busy", busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_bit("mid_reset_plot", plot, 1'b0);
      check_bit("mid_reset_busy", busy, 1'b0);
      exp_pix.delete();
      exp_done.delete();
      m_have_old = 1'b0;
      @(negedge clk);

      run_pass(0, 0, 3'b101, 1'b0);
      run_pass(254, 0, 3'b110, 1'b0);
      run_pass(158, 118, 3'b001, 1'b0);
      run_pass(255, 127, 3'b010, 1'b1);

      for (int k = 0; k < 20; k++) begin
         run_pass(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                  3'($urandom), 1'($urandom));
      end

      repeat (5) @(negedge clk);
      checks++;
      if (exp_pix.size() != 0 || exp_done.size() != 0) begin
         errors++;
         $display("FAIL leftover: got %0d pixels and %0d dones pending, expected 0 and 0",
                  exp_pix.size(), exp_done.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
